// File: rtl/mine_placer.sv
// Random mine layout generator: streams unique mine coordinates to the board
// memory after a start request, never placing a mine on the excluded field.
module mine_placer #(
    parameter int          MAX_DIM   = 15,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] level,
    input  logic [3:0] excl_x,
    input  logic [3:0] excl_y,
    output logic       busy,
    output logic       done,
    output logic       mine_wr,
    output logic [3:0] mine_x,
    output logic [3:0] mine_y,
    output logic [5:0] mine_cnt,
    output logic [3:0] board_dim,
    output logic [5:0] mine_num
);

    localparam logic [3:0]  E_ROW_COLUMN_NUMBER = 4'd8;
    localparam logic [3:0]  M_ROW_COLUMN_NUMBER = 4'd10;
    localparam logic [3:0]  H_ROW_COLUMN_NUMBER = 4'd15;
    localparam logic [5:0]  E_MINE_NUM          = 6'd19;
    localparam logic [5:0]  M_MINE_NUM          = 6'd30;
    localparam logic [5:0]  H_MINE_NUM          = 6'd40;
    localparam logic [15:0] LFSR_MASK           = 16'hB400;
    // An all-zero seed would lock the LFSR up forever.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [15:0]          lfsr_reg, lfsr_next;
    logic                 mine_wr_reg;
    logic [3:0]           mine_x_reg, mine_y_reg;
    logic [5:0]           mine_cnt_reg;
    logic [3:0]           board_dim_reg;
    logic [5:0]           mine_num_reg;
    logic [3:0]           excl_x_reg, excl_y_reg;
    logic [MAX_DIM-1:0]   occ_rows [MAX_DIM];

    logic [3:0]           cand_x, cand_y;
    logic                 in_range, occupied, excl_hit, accept, start_take;
    logic [5:0]           cnt_inc;
    logic [3:0]           level_dim;
    logic [5:0]           level_num;

    assign lfsr_next  = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);
    assign cand_x     = lfsr_reg[3:0];
    assign cand_y     = lfsr_reg[7:4];
    assign in_range   = (cand_x < board_dim_reg) && (cand_y < board_dim_reg);
    // Only meaningful when in_range; out-of-range reads are masked by accept.
    assign occupied   = occ_rows[cand_y][cand_x];
    assign excl_hit   = (cand_x == excl_x_reg) && (cand_y == excl_y_reg);
    assign accept     = (state_reg == PLACE) && in_range && !occupied && !excl_hit;
    assign start_take = (state_reg == IDLE) && start;
    assign cnt_inc    = mine_cnt_reg + 6'd1;

    always_comb begin
        level_dim = E_ROW_COLUMN_NUMBER;
        level_num = E_MINE_NUM;
        case (level)
            2'd1: begin
                level_dim = M_ROW_COLUMN_NUMBER;
                level_num = M_MINE_NUM;
            end
            2'd2: begin
                level_dim = H_ROW_COLUMN_NUMBER;
                level_num = H_MINE_NUM;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = PLACE;
            PLACE:   if (accept && (cnt_inc == mine_num_reg)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lfsr_reg      <= SEED_EFF;
            mine_wr_reg   <= 1'b0;
            mine_x_reg    <= 4'd0;
            mine_y_reg    <= 4'd0;
            mine_cnt_reg  <= 6'd0;
            board_dim_reg <= 4'd0;
            mine_num_reg  <= 6'd0;
            excl_x_reg    <= 4'd0;
            excl_y_reg    <= 4'd0;
        end else begin
            state_reg   <= state_next;
            lfsr_reg    <= lfsr_next;
            mine_wr_reg <= accept;
            if (start_take) begin
                board_dim_reg <= level_dim;
                mine_num_reg  <= level_num;
                excl_x_reg    <= excl_x;
                excl_y_reg    <= excl_y;
                mine_cnt_reg  <= 6'd0;
            end
            if (accept) begin
                mine_x_reg   <= cand_x;
                mine_y_reg   <= cand_y;
                mine_cnt_reg <= cnt_inc;
            end
        end
    end

    // Occupancy bitmap, one register row per board row so it can be cleared in one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIM; gi++) begin : g_row
            logic [MAX_DIM-1:0] row_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    row_reg <= '0;
                end else if (start_take) begin
                    row_reg <= '0;
                end else if (accept && (cand_y == 4'(gi))) begin
                    row_reg[cand_x] <= 1'b1;
                end
            end
            assign occ_rows[gi] = row_reg;
        end
    endgenerate

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign mine_wr   = mine_wr_reg;
    assign mine_x    = mine_x_reg;
    assign mine_y    = mine_y_reg;
    assign mine_cnt  = mine_cnt_reg;
    assign board_dim = board_dim_reg;
    assign mine_num  = mine_num_reg;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: a cycle model predicts every mine write into a queue,
// and a negedge monitor pops and compares each write the DUT produces.
module tb_mine_placer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] level = 2'd0;
    logic [3:0] excl_x = 4'd0, excl_y = 4'd0;
    logic       busy, done, mine_wr;
    logic [3:0] mine_x, mine_y, board_dim;
    logic [5:0] mine_cnt, mine_num;

    mine_placer #(.MAX_DIM(15), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .level(level),
        .excl_x(excl_x), .excl_y(excl_y), .busy(busy), .done(done),
        .mine_wr(mine_wr), .mine_x(mine_x), .mine_y(mine_y),
        .mine_cnt(mine_cnt), .board_dim(board_dim), .mine_num(mine_num)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [5:0] cnt;
        logic       last;
    } wr_t;
    wr_t exp_q[$];

    function automatic logic [3:0] dim_of(input logic [1:0] l);
        if (l == 2'd1) return 4'd10;
        if (l == 2'd2) return 4'd15;
        return 4'd8;
    endfunction

    function automatic logic [5:0] num_of(input logic [1:0] l);
        if (l == 2'd1) return 6'd30;
        if (l == 2'd2) return 6'd40;
        return 6'd19;
    endfunction

    // Reference model of the placer, stepped on every rising edge.
    logic [15:0] m_lfsr;
    int          m_state;
    logic [3:0]  m_dim, m_ex, m_ey;
    logic [5:0]  m_num, m_cnt;
    logic        m_occ [16][16];

    always @(posedge clk) begin : model
        logic [3:0] cx, cy;
        if (!rst_n) begin
            m_lfsr  = 16'hACE1;
            m_state = 0;
            m_cnt   = 6'd0;
            m_dim   = 4'd0;
            m_num   = 6'd0;
        end else begin
            cx = m_lfsr[3:0];
            cy = m_lfsr[7:4];
            if (m_state == 0) begin
                if (start) begin
                    m_dim = dim_of(level);
                    m_num = num_of(level);
                    m_ex  = excl_x;
                    m_ey  = excl_y;
                    m_cnt = 6'd0;
                    foreach (m_occ[i, j]) m_occ[i][j] = 1'b0;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (cx < m_dim && cy < m_dim && !m_occ[cy][cx] && !(cx == m_ex && cy == m_ey)) begin
                    m_occ[cy][cx] = 1'b1;
                    m_cnt = m_cnt + 6'd1;
                    exp_q.push_back('{x: cx, y: cy, cnt: m_cnt, last: (m_cnt == m_num)});
                    if (m_cnt == m_num) m_state = 2;
                end
            end else begin
                m_state = 0;
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    // Per-layout bookkeeping, independent of the model.
    int         run_writes, run_bad, run_done;
    logic       run_seen [16][16];
    logic [3:0] run_dim, run_ex, run_ey;

    always @(negedge clk) begin : monitor
        wr_t e;
        if (done) run_done++;
        if (mine_wr) begin
            run_writes++;
            if (mine_x >= run_dim || mine_y >= run_dim || run_seen[mine_y][mine_x] ||
                (mine_x == run_ex && mine_y == run_ey)) run_bad++;
            run_seen[mine_y][mine_x] = 1'b1;
        end
        if (mine_wr || exp_q.size() != 0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got (%0d,%0d) cnt=%0d, required no write", mine_x, mine_y, mine_cnt);
            end else begin
                e = exp_q.pop_front();
                if (mine_wr !== 1'b1 || mine_x !== e.x || mine_y !== e.y || mine_cnt !== e.cnt || done !== e.last) begin
                    miscompares++;
                    $display("FAIL mine_write: got wr=%0b (%0d,%0d) cnt=%0d done=%0b, required wr=1 (%0d,%0d) cnt=%0d done=%0b",
                             mine_wr, mine_x, mine_y, mine_cnt, done, e.x, e.y, e.cnt, e.last);
                end
            end
        end
    end

    task automatic clear_run(input logic [3:0] d, input logic [3:0] ex, input logic [3:0] ey);
        run_writes = 0;
        run_bad    = 0;
        run_done   = 0;
        run_dim    = d;
        run_ex     = ex;
        run_ey     = ey;
        foreach (run_seen[i, j]) run_seen[i][j] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || mine_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy=%0b done=%0b wr=%0b, required 0 0 0", busy, done, mine_wr);
        end
        vectors++;
        if (mine_x !== 4'd0 || mine_y !== 4'd0 || mine_cnt !== 6'd0 || board_dim !== 4'd0 || mine_num !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_data: got x=%0d y=%0d cnt=%0d dim=%0d num=%0d, required all 0",
                     mine_x, mine_y, mine_cnt, board_dim, mine_num);
        end
        rst_n = 1'b1;
        $display("reset: busy=%0b cnt=%0d dim=%0d", busy, mine_cnt, board_dim);
    endtask

    // One complete layout; hold keeps start high and scrambles excl/level while busy.
    task automatic test_layout(input logic [1:0] lvl, input logic [3:0] ex, input logic [3:0] ey, input bit hold);
        logic [3:0] e_dim;
        logic [5:0] e_num;
        int cyc;
        e_dim = dim_of(lvl);
        e_num = num_of(lvl);
        @(posedge clk); #1;
        clear_run(e_dim, ex, ey);
        level = lvl; excl_x = ex; excl_y = ey; start = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_rise: got busy=%0b, required 1", busy);
        end
        if (!hold) start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            if (hold) begin
                excl_x = 4'($urandom);
                excl_y = 4'($urandom);
                level  = 2'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: got done=%0b after %0d cycles, required 1", done, cyc);
        end
        vectors++;
        if (mine_wr !== 1'b1 || busy !== 1'b1 || cyc < int'(e_num)) begin
            miscompares++;
            $display("FAIL done_align: got wr=%0b busy=%0b cycles=%0d, required wr=1 busy=1 cycles>=%0d",
                     mine_wr, busy, cyc, e_num);
        end
        vectors++;
        if (mine_cnt !== e_num || board_dim !== e_dim || mine_num !== e_num) begin
            miscompares++;
            $display("FAIL latched: got cnt=%0d dim=%0d num=%0d, required cnt=%0d dim=%0d num=%0d",
                     mine_cnt, board_dim, mine_num, e_num, e_dim, e_num);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || mine_wr !== 1'b0 || mine_cnt !== e_num) begin
            miscompares++;
            $display("FAIL done_fall: got busy=%0b done=%0b wr=%0b cnt=%0d, required 0 0 0 %0d",
                     busy, done, mine_wr, mine_cnt, e_num);
        end
        vectors++;
        if (run_writes != int'(e_num) || run_done != 1 || run_bad != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL layout: got writes=%0d done_pulses=%0d bad=%0d pending=%0d, required %0d 1 0 0",
                     run_writes, run_done, run_bad, exp_q.size(), e_num);
        end
        $display("layout level=%0d excl=(%0d,%0d) hold=%0b writes=%0d cycles=%0d",
                 lvl, ex, ey, hold, run_writes, cyc + 1);
    endtask

    task automatic test_reset_mid_place();
        int cyc;
        @(posedge clk); #1;
        clear_run(4'd15, 4'd0, 4'd0);
        level = 2'd2; excl_x = 4'd0; excl_y = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (run_writes < 5 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (run_writes < 5 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_place: got writes=%0d busy=%0b, required >=5 and busy=1", run_writes, busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || mine_wr !== 1'b0 || mine_x !== 4'd0 || mine_y !== 4'd0 ||
            mine_cnt !== 6'd0 || board_dim !== 4'd0 || mine_num !== 6'd0) begin
            miscompares++;
            $display("FAIL abort_reset: got busy=%0b done=%0b wr=%0b x=%0d y=%0d cnt=%0d dim=%0d num=%0d, required all 0",
                     busy, done, mine_wr, mine_x, mine_y, mine_cnt, board_dim, mine_num);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (mine_wr !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got wr=%0b pending=%0d, required 0 0", mine_wr, exp_q.size());
        end
        $display("abort after %0d writes, cnt=%0d", run_writes, mine_cnt);
        test_layout(2'd0, 4'd5, 4'd2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_layout(2'd0, 4'd3, 4'd3, 1'b0);
        test_layout(2'd1, 4'd4, 4'd7, 1'b0);
        test_layout(2'd2, 4'd14, 4'd0, 1'b0);
        test_layout(2'd3, 4'd0, 4'd0, 1'b0);
        test_layout(2'd0, 4'd15, 4'd15, 1'b0);
        test_layout(2'd1, 4'd2, 4'd6, 1'b1);
        test_reset_mid_place();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
